// File: rtl/range_stats_if.sv
// Sample/result bundle for range_stats. The count signal exists only when
// RANGE_STATS_COUNT_EN is defined; state_dbg exposes the FSM state.
interface range_stats_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] data_in;
  logic             go;
  logic             finish;
  logic [1:0]       mode;
  logic [WIDTH-1:0] result;
  logic             valid;
  logic             busy;
  logic             debug_error;
  logic [1:0]       state_dbg;
`ifdef RANGE_STATS_COUNT_EN
  logic [CNT_W-1:0] count;
`endif

  // Sequence framing: go marks the first sample, finish the last; valid is a
  // one-cycle pulse with result (and count) stable until the next pulse.
  modport master (
    output data_in, go, finish, mode,
    input  result, valid, busy, debug_error, state_dbg
`ifdef RANGE_STATS_COUNT_EN
    , input count
`endif
  );

  modport slave (
    input  data_in, go, finish, mode,
    output result, valid, busy, debug_error, state_dbg
`ifdef RANGE_STATS_COUNT_EN
    , output count
`endif
  );
endinterface

// File: rtl/range_stats.sv
// Streaming min/max tracker reporting range, max, min or midpoint per sequence.
// Optional sample counter compiled in with RANGE_STATS_COUNT_EN.
module range_stats #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input logic         clock,
  input logic         reset,
  range_stats_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ERROR = 2'd2
  } state_t;

  generate
    if (WIDTH < 2 || CNT_W < 1) begin : g_bad_param
      $error("range_stats: WIDTH must be >= 2 and CNT_W >= 1");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] min_r;
  logic [WIDTH-1:0] max_r;
  logic [1:0]       mode_r;
  logic [WIDTH-1:0] result_r;
  logic             valid_r;
  logic             error_r;

  logic [WIDTH-1:0] nxt_min;
  logic [WIDTH-1:0] nxt_max;
  logic [WIDTH:0]   mid_sum;
  logic [WIDTH-1:0] sel;

  // Final statistics include the sample presented alongside finish.
  always_comb begin
    nxt_max = (bus.data_in > max_r) ? bus.data_in : max_r;
    nxt_min = (bus.data_in < min_r) ? bus.data_in : min_r;
    mid_sum = {1'b0, nxt_max} + {1'b0, nxt_min};
    sel     = nxt_max - nxt_min;
    case (mode_r)
      2'b01:   sel = nxt_max;
      2'b10:   sel = nxt_min;
      2'b11:   sel = mid_sum[WIDTH:1];
      default: sel = nxt_max - nxt_min;
    endcase
  end

`ifdef RANGE_STATS_COUNT_EN
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] cnt_nxt;
  assign cnt_nxt   = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + 1'b1;
  assign bus.count = count_r;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      min_r    <= '0;
      max_r    <= '0;
      mode_r   <= 2'b00;
      result_r <= '0;
      valid_r  <= 1'b0;
      error_r  <= 1'b0;
`ifdef RANGE_STATS_COUNT_EN
      cnt_r    <= '0;
      count_r  <= '0;
`endif
    end else begin
      valid_r <= 1'b0;
      case (state)
        IDLE, ERROR: begin
          if (bus.finish) begin
            state   <= ERROR;
            error_r <= 1'b1;
          end else if (bus.go) begin
            state   <= RUN;
            error_r <= 1'b0;
            min_r   <= bus.data_in;
            max_r   <= bus.data_in;
            mode_r  <= bus.mode;
`ifdef RANGE_STATS_COUNT_EN
            cnt_r   <= {{(CNT_W-1){1'b0}}, 1'b1};
`endif
          end
        end
        RUN: begin
          if (bus.go) begin
            state   <= ERROR;
            error_r <= 1'b1;
          end else if (bus.finish) begin
            state    <= IDLE;
            result_r <= sel;
            valid_r  <= 1'b1;
`ifdef RANGE_STATS_COUNT_EN
            count_r  <= cnt_nxt;
`endif
          end else begin
            min_r <= nxt_min;
            max_r <= nxt_max;
`ifdef RANGE_STATS_COUNT_EN
            cnt_r <= cnt_nxt;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.result      = result_r;
  assign bus.valid       = valid_r;
  assign bus.busy        = (state == RUN);
  assign bus.debug_error = error_r;
  assign bus.state_dbg   = state;
endmodule

// File: tb/tb_range_stats.sv
// Directed self-checking bench for range_stats (WIDTH=8); count checks are
// active only when RANGE_STATS_COUNT_EN is defined.
module tb_range_stats;
  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  range_stats_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  range_stats #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // driver tasks
  task automatic drive(input logic g, input logic f, input logic [7:0] d, input logic [1:0] m);
    bus.go      = g;
    bus.finish  = f;
    bus.data_in = d;
    bus.mode    = m;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 8'd0, 2'b00);
    reset = 1'b0;
    #12;
    total++;
    if ({bus.result, bus.valid, bus.busy, bus.debug_error, bus.state_dbg} !== 13'd0) begin
      bad++;
      $display("FAIL reset_state: got result=%0d valid=%b busy=%b err=%b state=%0d, want all 0",
               bus.result, bus.valid, bus.busy, bus.debug_error, bus.state_dbg);
    end
    @(negedge clock);
    reset = 1'b1;
    step();
  endtask

  task automatic test_modes();
    logic [1:0] modes [4];
    logic [7:0] exp_r [4];
    modes[0] = 2'b00; exp_r[0] = 8'd47;
    modes[1] = 2'b11; exp_r[1] = 8'd26;
    modes[2] = 2'b01; exp_r[2] = 8'd50;
    modes[3] = 2'b10; exp_r[3] = 8'd3;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 8'd10, modes[i]);
      step();
      total++;
      if (bus.busy !== 1'b1 || bus.state_dbg !== 2'd1) begin
        bad++;
        $display("FAIL mode%0d_busy: got busy=%b state=%0d, want 1/1", i, bus.busy, bus.state_dbg);
      end
      // mode toggles mid-sequence must be ignored
      drive(1'b0, 1'b0, 8'd50, ~modes[i]);
      step();
      drive(1'b0, 1'b0, 8'd3, ~modes[i]);
      step();
      drive(1'b0, 1'b1, 8'd20, ~modes[i]);
      step();
      total++;
      if (bus.result !== exp_r[i] || bus.valid !== 1'b1 || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL mode%0d_result: got result=%0d valid=%b busy=%b, want %0d/1/0",
                 i, bus.result, bus.valid, bus.busy, exp_r[i]);
      end
`ifdef RANGE_STATS_COUNT_EN
      total++;
      if (bus.count !== 16'd4) begin
        bad++;
        $display("FAIL mode%0d_count: got %0d, want 4", i, bus.count);
      end
`endif
      drive(1'b0, 1'b0, 8'd99, 2'b00);
      step();
      total++;
      if (bus.valid !== 1'b0 || bus.result !== exp_r[i]) begin
        bad++;
        $display("FAIL mode%0d_hold: got valid=%b result=%0d, want 0/%0d",
                 i, bus.valid, bus.result, exp_r[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 8'd100, 2'b01);
    step();
    drive(1'b0, 1'b0, 8'd200, 2'b01);
    step();
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({bus.result, bus.valid, bus.busy, bus.debug_error, bus.state_dbg} !== 13'd0) begin
      bad++;
      $display("FAIL reset_mid: got result=%0d valid=%b busy=%b err=%b state=%0d, want all 0",
               bus.result, bus.valid, bus.busy, bus.debug_error, bus.state_dbg);
    end
    drive(1'b0, 1'b0, 8'd0, 2'b00);
    @(negedge clock);
    reset = 1'b1;
    drive(1'b1, 1'b0, 8'd9, 2'b00);
    step();
    drive(1'b0, 1'b1, 8'd1, 2'b00);
    step();
    total++;
    if (bus.result !== 8'd8 || bus.valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_fresh: got result=%0d valid=%b, want 8/1", bus.result, bus.valid);
    end
  endtask

  task automatic test_idle_finish();
    drive(1'b0, 1'b1, 8'd77, 2'b00);
    step();
    total++;
    if (bus.debug_error !== 1'b1 || bus.valid !== 1'b0 || bus.result !== 8'd8 || bus.state_dbg !== 2'd2) begin
      bad++;
      $display("FAIL idle_finish: got err=%b valid=%b result=%0d state=%0d, want 1/0/8/2",
               bus.debug_error, bus.valid, bus.result, bus.state_dbg);
    end
    drive(1'b0, 1'b0, 8'd0, 2'b00);
    step();
    total++;
    if (bus.debug_error !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL error_hold: got err=%b busy=%b, want 1/0", bus.debug_error, bus.busy);
    end
    drive(1'b1, 1'b0, 8'd7, 2'b00);
    step();
    total++;
    if (bus.debug_error !== 1'b0 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL error_recover: got err=%b busy=%b, want 0/1", bus.debug_error, bus.busy);
    end
    drive(1'b0, 1'b1, 8'd7, 2'b00);
    step();
    total++;
    if (bus.result !== 8'd0 || bus.valid !== 1'b1) begin
      bad++;
      $display("FAIL single_value: got result=%0d valid=%b, want 0/1", bus.result, bus.valid);
    end
  endtask

  task automatic test_double_go();
    drive(1'b1, 1'b0, 8'd5, 2'b01);
    step();
    drive(1'b1, 1'b0, 8'd5, 2'b01);
    step();
    total++;
    if (bus.debug_error !== 1'b1 || bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.result !== 8'd0) begin
      bad++;
      $display("FAIL double_go: got err=%b busy=%b valid=%b result=%0d, want 1/0/0/0",
               bus.debug_error, bus.busy, bus.valid, bus.result);
    end
  endtask

  task automatic test_boundary();
    drive(1'b1, 1'b1, 8'd255, 2'b00);
    step();
    total++;
    if (bus.state_dbg !== 2'd2 || bus.debug_error !== 1'b1 || bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
      bad++;
      $display("FAIL go_finish_idle: got state=%0d err=%b busy=%b valid=%b, want 2/1/0/0",
               bus.state_dbg, bus.debug_error, bus.busy, bus.valid);
    end
    drive(1'b1, 1'b0, 8'd255, 2'b11);
    step();
    drive(1'b0, 1'b1, 8'd0, 2'b00);
    step();
    total++;
    if (bus.result !== 8'd127 || bus.valid !== 1'b1 || bus.debug_error !== 1'b0) begin
      bad++;
      $display("FAIL midpoint_wide: got result=%0d valid=%b err=%b, want 127/1/0",
               bus.result, bus.valid, bus.debug_error);
    end
`ifdef RANGE_STATS_COUNT_EN
    total++;
    if (bus.count !== 16'd2) begin
      bad++;
      $display("FAIL boundary_count: got %0d, want 2", bus.count);
    end
`endif
    drive(1'b0, 1'b0, 8'd0, 2'b00);
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    drive(1'b0, 1'b0, 8'd0, 2'b00);
    test_reset();
    test_modes();
    test_reset_mid();
    test_idle_finish();
    test_double_go();
    test_boundary();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
